// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Pipeline sequencing controller for the five-stage core. It produces the
//   freeze/flush controls for the PC, IF/ID and ID/EX registers, detects RAW
//   hazards between ID and the later stages, and applies branch-taken flushes.
//   A small FSM freezes the whole pipeline while a memory access waits on the
//   SRAM. A watchdog halts the core if the SRAM never answers. Saturating
//   counters collect stall and flush statistics.
//
//   Build option: define HAZARD_FORWARDING_EN when the datapath forwards
//   results. A hazard is then raised only for load-use against EXE. Without
//   it, any pending write in EXE or MEM to a source register stalls ID.
//
// Parameters
//   TIMEOUT  extra wait cycles tolerated for mem_ready_i (1..255)
//   CNT_W    width of the statistics counters
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   id_*_i            ID instruction: valid, sources, second-source-used
//   exe_*_i, mem_*_i  destination / write-back info of the EXE and MEM stages
//   branch_taken_i    EXE resolved a taken branch
//   mem_req_i         MEM issues a load/store; mem_ready_i: SRAM done
//   cnt_clr_i         synchronous clear of the statistics counters
//   freeze_pc_o       hold PC and IF/ID
//   flush_ifid_o      clear IF/ID
//   flush_idex_o      bubble into ID/EX
//   freeze_all_o      hold PC and every stage register
//   halted_o          watchdog expired (registered)
//   stall_cnt_o       cycles with any freeze
//   flush_cnt_o       branch flush events
//
// State | meaning
//   RUN      | normal flow; a memory request without ready starts a wait
//   MEM_WAIT | waiting for mem_ready_i; pipeline frozen
//   HALT     | watchdog expired; pipeline frozen until reset
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid_i,
  input  logic [3:0]       id_src1_i,
  input  logic [3:0]       id_src2_i,
  input  logic             id_two_src_i,
  input  logic [3:0]       exe_dest_i,
  input  logic             exe_wb_en_i,
  input  logic             exe_mem_r_en_i,
  input  logic [3:0]       mem_dest_i,
  input  logic             mem_wb_en_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  input  logic             cnt_clr_i,
  output logic             freeze_pc_o,
  output logic             flush_ifid_o,
  output logic             flush_idex_o,
  output logic             freeze_all_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic hz;
  logic freeze_all;
  logic branch_evt;

  // ---------------------------------------------------------------------------
  // RAW hazard detection
  // ---------------------------------------------------------------------------
`ifdef HAZARD_FORWARDING_EN
  // Forwarding covers ALU results; only a load in EXE cannot be bypassed yet.
  logic exe_is_load;
  logic unused_mem_fields;

  assign exe_is_load = exe_wb_en_i & exe_mem_r_en_i;
  assign hz = id_valid_i & exe_is_load &
              ((id_src1_i == exe_dest_i) |
               (id_two_src_i & (id_src2_i == exe_dest_i)));
  assign unused_mem_fields = ^{mem_dest_i, mem_wb_en_i};
`else
  logic exe_match;
  logic mem_match;
  logic unused_load_flag;

  assign exe_match = exe_wb_en_i &
                     ((id_src1_i == exe_dest_i) |
                      (id_two_src_i & (id_src2_i == exe_dest_i)));
  assign mem_match = mem_wb_en_i &
                     ((id_src1_i == mem_dest_i) |
                      (id_two_src_i & (id_src2_i == mem_dest_i)));
  assign hz = id_valid_i & (exe_match | mem_match);
  assign unused_load_flag = exe_mem_r_en_i;
`endif

  // ---------------------------------------------------------------------------
  // Memory-wait FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      RUN: begin
        if (mem_req_i && !mem_ready_i) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready_i) begin
          state_d = RUN;
        end else if (wait_cnt_q == 8'(TIMEOUT)) begin
          state_d = HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // The request cycle itself is frozen, and ready releases the freeze in the
  // same cycle so the pipeline advances on that edge.
  assign freeze_all = ((state_q == RUN) & mem_req_i & ~mem_ready_i) |
                      ((state_q == MEM_WAIT) & ~mem_ready_i) |
                      (state_q == HALT);

  // ---------------------------------------------------------------------------
  // Output priority: freeze > branch flush > hazard stall.
  // During a freeze the frozen EXE/ID contents re-present branch and hazard
  // once the freeze releases, so nothing is lost by suppressing them here.
  // ---------------------------------------------------------------------------
  assign branch_evt = ~freeze_all & branch_taken_i;

  always_comb begin
    freeze_pc_o  = 1'b0;
    flush_ifid_o = 1'b0;
    flush_idex_o = 1'b0;
    if (freeze_all) begin
      freeze_pc_o  = 1'b0;
    end else if (branch_taken_i) begin
      flush_ifid_o = 1'b1;
      flush_idex_o = 1'b1;
    end else if (hz) begin
      freeze_pc_o  = 1'b1;
      flush_idex_o = 1'b1;
    end
  end

  assign freeze_all_o = freeze_all;
  assign halted_o     = (state_q == HALT);

  // ---------------------------------------------------------------------------
  // Saturating statistics counters; clear wins over increment.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr_i) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if ((freeze_pc_o | freeze_all) && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (branch_evt && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl. Directed vectors with hand-computed
// expected outputs are queued by the stimulus process; a monitor pops one
// entry per cycle on the falling edge and compares.
module tb_pipe_hazard_ctrl;

  localparam int CW = 4;
  localparam int TO = 4;
`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic branch_taken, mem_req, mem_ready, cnt_clr;
  logic freeze_pc, flush_ifid, flush_idex, freeze_all, halted;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid), .id_src1_i(id_src1), .id_src2_i(id_src2),
    .id_two_src_i(id_two_src), .exe_dest_i(exe_dest), .exe_wb_en_i(exe_wb_en),
    .exe_mem_r_en_i(exe_mem_r_en), .mem_dest_i(mem_dest), .mem_wb_en_i(mem_wb_en),
    .branch_taken_i(branch_taken), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
    .cnt_clr_i(cnt_clr), .freeze_pc_o(freeze_pc), .flush_ifid_o(flush_ifid),
    .flush_idex_o(flush_idex), .freeze_all_o(freeze_all), .halted_o(halted),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  typedef struct packed {
    logic          fpc, fif, fid, fall, halt;
    logic [CW-1:0] st, fl;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_mis = 0;
  logic [CW-1:0] m_st = '0;
  logic [CW-1:0] m_fl = '0;

  // Monitor: one expected entry per cycle, compared on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e, a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = '{freeze_pc, flush_ifid, flush_idex, freeze_all, halted, stall_cnt, flush_cnt};
      n_cmp++;
      if (a !== e) begin
        n_mis++;
        $display("FAIL %s: got fpc/fif/fid/fall/halt=%b%b%b%b%b st=%0d fl=%0d, required %b%b%b%b%b st=%0d fl=%0d",
                 n, a.fpc, a.fif, a.fid, a.fall, a.halt, a.st, a.fl,
                 e.fpc, e.fif, e.fid, e.fall, e.halt, e.st, e.fl);
      end
    end
  end

  task automatic idle();
    id_valid = 0; id_two_src = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_wb_en = 0;
    id_src1 = 0; id_src2 = 0; exe_dest = 0; mem_dest = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0; cnt_clr = 0;
  endtask

  task automatic load_use();
    id_valid = 1; exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 4'd3; id_src1 = 4'd3;
  endtask

  // Queue the expected outputs for the current cycle, then advance the
  // expected counters by the events this cycle is expected to produce.
  task automatic push(input string n, input bit fpc, input bit fif, input bit fid,
                      input bit fall, input bit halt);
    if (rst) begin
      m_st = '0;
      m_fl = '0;
    end
    exp_q.push_back('{fpc, fif, fid, fall, halt, m_st, m_fl});
    name_q.push_back(n);
    if (!rst) begin
      if (cnt_clr) begin
        m_st = '0;
        m_fl = '0;
      end else begin
        if ((fpc || fall) && m_st != '1) m_st = m_st + 1'b1;
        if (fif && m_fl != '1) m_fl = m_fl + 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 0;

    push("reset", 0, 0, 0, 0, 0);

    load_use();
    push("load_use", 1, 0, 1, 0, 0);
    idle();
    push("after_load_use", 0, 0, 0, 0, 0);

    exe_wb_en = 1; exe_dest = 4'd5; id_src1 = 4'd0; id_src2 = 4'd5;
    id_two_src = 1; id_valid = 1;
    push("alu_raw_src2", !FWD, 0, !FWD, 0, 0);
    id_two_src = 0;
    push("src2_unused", 0, 0, 0, 0, 0);

    idle();
    mem_wb_en = 1; mem_dest = 4'd7; id_src1 = 4'd7; id_valid = 1;
    push("mem_raw", !FWD, 0, !FWD, 0, 0);

    idle();
    load_use(); id_valid = 0;
    push("id_invalid", 0, 0, 0, 0, 0);

    load_use(); branch_taken = 1;
    push("branch_hz", 0, 1, 1, 0, 0);
    idle();
    push("after_branch", 0, 0, 0, 0, 0);

    // Memory wait with branch held: flushes deferred to the release cycle.
    mem_req = 1; branch_taken = 1;
    push("mw_req", 0, 0, 0, 1, 0);
    push("mw_wait1", 0, 0, 0, 1, 0);
    push("mw_wait2", 0, 0, 0, 1, 0);
    mem_ready = 1;
    push("mw_release", 0, 1, 1, 0, 0);
    idle();
    push("mw_after", 0, 0, 0, 0, 0);

    mem_req = 1; mem_ready = 1;
    push("req_ready_run", 0, 0, 0, 0, 0);
    idle();
    push("req_ready_after", 0, 0, 0, 0, 0);

    // Watchdog: freeze N..N+TO, halted from N+TO+1.
    mem_req = 1;
    push("wd_n", 0, 0, 0, 1, 0);
    mem_req = 0;
    for (int i = 1; i <= TO; i++) push("wd_wait", 0, 0, 0, 1, 0);
    push("wd_halt", 0, 0, 0, 1, 1);
    mem_ready = 1; branch_taken = 1;
    push("wd_late_ready", 0, 0, 0, 1, 1);
    mem_ready = 0; branch_taken = 0; cnt_clr = 1;
    push("wd_clr", 0, 0, 0, 1, 1);
    cnt_clr = 0;
    push("wd_after_clr", 0, 0, 0, 1, 1);
    push("wd_cnt_one", 0, 0, 0, 1, 1);
    rst = 1;
    push("wd_rst", 0, 0, 0, 0, 0);
    rst = 0;
    push("wd_post_rst", 0, 0, 0, 0, 0);

    // Long hazard stall saturates stall_cnt; then clear during a stall.
    load_use();
    for (int i = 0; i < 20; i++) push("sat_hold", 1, 0, 1, 0, 0);
    cnt_clr = 1;
    push("clr_in_stall", 1, 0, 1, 0, 0);
    idle();
    push("after_clr", 0, 0, 0, 0, 0);

    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL drain: got %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
